dsc_mul_nway: RTL and testbench
===============================

Name: dsc_mul_nway

Overview:
- Parametrised deterministic stochastic-computing (DSC) multiplier for N unsigned W-bit operands, using the clock-division method.
- Replaces ripple-clocked counter cascades with a single-clock, enable-chained counter set.
- Adds a start/busy/done handshake, pause support, and an optional zero-operand early exit.
- Sits between binary operand registers and downstream binary logic; the result is the exact integer product.

Parameters:
- N_IN, 3, number of operands (2..8)
- W, 4, bits per operand (1..8)
- EARLY_EXIT, 0, 1 = finish immediately if any latched operand is zero

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; low freezes an in-progress run
- start  in  1  one-cycle request; accepted only when busy=0
- ops  in  N_IN*W  packed operands; operand k = ops[k*W +: W]
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse; z is valid from this cycle onward
- z  out  N_IN*W  product, held until the next accepted start
- ov  out  1  level, high after completion and until the next start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, ov=0, z=0.
  - All digit counters, the accumulator and the operand latches are 0.
  - Reset is honoured at any time, including mid-run; the partial result is discarded.
- States:
  - IDLE -> RUN on start (cycle t): latch ops, clear the counters and the accumulator, busy=1, ov=0.
  - With EARLY_EXIT=1 and any operand zero: IDLE -> DONE instead of RUN, z=0.
  - RUN -> DONE after the final count cycle.
  - DONE -> IDLE unconditionally after one cycle; done=1 only in DONE.
- Counters:
  - N_IN digit counters, each W bits.
  - Digit 0 increments on every RUN cycle with en=1.
  - Digit k increments only when en=1 and digits 0..k-1 are all at 2^W-1 (carry chain). This is the single-clock equivalent of clocking digit k from digit k-1's overflow.
  - All digits wrap to 0 together at the end of the run.
- Stochastic bits:
  - s_k = (operand_k > digit_k), unsigned compare.
  - Product bit p = AND of s_0..s_{N_IN-1}.
  - The accumulator increments when en=1 and p=1.
- Width rule: the accumulator is N_IN*W bits. The maximum (2^W-1)^N_IN fits, so it never overflows.
- Latency:
  - RUN spans exactly 2^(N_IN*W) enabled cycles (default 4096).
  - done pulses on the cycle after the last enabled count cycle, and z=accumulator is registered there.
  - Total from start = 2^(N_IN*W)+1 enabled cycles, plus any en=0 cycles.
- Pause: en=0 during RUN holds all counters and the accumulator. busy stays 1; no other effect.
- en in other states: en=0 in IDLE does not block start. Latching happens regardless; counting waits for en.
- Start collisions:
  - start while busy=1 is ignored; ops changes during RUN are ignored.
  - start in the DONE cycle is ignored. Start is accepted from the next IDLE cycle.
- Completion: ov rises with done and stays high until the next accepted start. z holds its value across IDLE.
- Exactness: the result equals the integer product for all operand values, including zeros and all-max operands.

Decomposition:
- Package dsc_pkg:
  - DSC_MAX_IN, DSC_MAX_W constants
  - state enum {IDLE, RUN, DONE}
  - function prod_width(n,w)=n*w
- Sub-module dsc_digit_ctr, instantiated N_IN times:
  - Contents: one W-bit counter with carry_in, carry_out (all-ones AND carry_in), synchronous clear, and the operand comparator.
  - Output: s_k.

Test Plan:
- Defaults, ops = {15,15,15}, en held high -> z=3375, done exactly 4097 cycles after start, ov=1 after.
- ops = {3,5,7} -> z=105; then ops = {0,9,4} with EARLY_EXIT=0 -> z=0 after the full 4097 cycles. Same with EARLY_EXIT=1 -> done on cycle t+1, z=0.
- ops = {10,6,13}, en dropped for 100 cycles at count 2000 -> z=780, done at t+4197, busy continuously high.
- Reset mid-run, then pulse start twice during a new run with ops = {2,2,2} -> after reset busy=0, z=0, ov=0; second start ignored; z=8.
- Parameters N_IN=2, W=3, exhaustive sweep of all 64 operand pairs -> z = a*b every time, latency 65 cycles each.
- Back-to-back: start asserted on the DONE cycle, then again on the following IDLE cycle -> first ignored, second accepted; the previous z is held until the new done.

Source files
------------

// File: rtl/dsc_pkg.sv
// Shared types and constants for the deterministic stochastic-computing multiplier.
package dsc_pkg;

    localparam int DSC_MAX_IN = 8;
    localparam int DSC_MAX_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dsc_state_e;

    function automatic int prod_width(input int n, input int w);
        return n * w;
    endfunction

endpackage

// File: rtl/dsc_digit_ctr.sv
// One digit of the enable-chained counter set: W-bit counter, operand latch and
// the comparator that produces this digit's stochastic bit.
module dsc_digit_ctr
    import dsc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] op_in,
    input  logic         carry_in,
    output logic         carry_out,
    output logic         s
);

    logic [W-1:0] cnt_r;
    logic [W-1:0] op_r;

    // Carry ripples onward only when this digit is about to wrap.
    assign carry_out = carry_in & (cnt_r == {W{1'b1}});
    assign s         = (op_r > cnt_r);

    // Digit counter: cleared on a new run, advanced by the incoming carry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (carry_in) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Operand latch, captured once when a run is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r <= {W{1'b0}};
        end else if (load) begin
            op_r <= op_in;
        end else begin
            op_r <= op_r;
        end
    end

endmodule

// File: rtl/dsc_mul_nway.sv
// N-operand DSC multiplier (clock-division method) on a single clock with a
// start/busy/done handshake, pause via en, and optional zero-operand early exit.
module dsc_mul_nway
    import dsc_pkg::*;
#(
    parameter int N_IN       = 3,
    parameter int W          = 4,
    parameter int EARLY_EXIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [N_IN*W-1:0] ops,
    output logic              busy,
    output logic              done,
    output logic [N_IN*W-1:0] z,
    output logic              ov
);

    localparam int PW = prod_width(N_IN, W);

    dsc_state_e      state_r;
    dsc_state_e      state_n;
    logic            run_s;
    logic            accept_s;
    logic            zero_s;
    logic            early_s;
    logic            last_s;
    logic            acc_inc_s;
    logic [N_IN:0]   carry_s;
    logic [N_IN-1:0] s_vec_s;
    logic [PW-1:0]   acc_r;
    logic [PW-1:0]   acc_next_s;
    logic [PW-1:0]   z_r;
    logic [PW-1:0]   z_n;
    logic            busy_r;
    logic            busy_n;
    logic            done_r;
    logic            done_n;
    logic            ov_r;
    logic            ov_n;

    assign run_s      = (state_r == RUN);
    assign accept_s   = (state_r == IDLE) && start;
    assign carry_s[0] = run_s & en;

    for (genvar k = 0; k < N_IN; k++) begin : g_digit
        dsc_digit_ctr #(.W(W)) u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (accept_s),
            .load      (accept_s),
            .op_in     (ops[k*W +: W]),
            .carry_in  (carry_s[k]),
            .carry_out (carry_s[k+1]),
            .s         (s_vec_s[k])
        );
    end

    // The carry out of the top digit marks the final count cycle of the run.
    assign last_s     = carry_s[N_IN];
    assign acc_inc_s  = run_s & en & (&s_vec_s);
    assign acc_next_s = acc_r + {{(PW-1){1'b0}}, acc_inc_s};

    // Any zero operand on the incoming bus (used only for early exit).
    always_comb begin
        zero_s = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            zero_s = zero_s | (ops[k*W +: W] == {W{1'b0}});
        end
    end

    assign early_s = (EARLY_EXIT != 0) && zero_s;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = early_s ? DONE : RUN;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = RUN;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values of the registered handshake and result.
    always_comb begin
        busy_n = (state_n == RUN);
        done_n = (state_n == DONE);
        z_n    = z_r;
        ov_n   = ov_r;
        if (state_n == DONE) begin
            ov_n = 1'b1;
        end else if (accept_s) begin
            ov_n = 1'b0;
        end else begin
            ov_n = ov_r;
        end
        // The previous product stays visible until the new one is ready.
        if (run_s && last_s) begin
            z_n = acc_next_s;
        end else if (accept_s && early_s) begin
            z_n = {PW{1'b0}};
        end else begin
            z_n = z_r;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            ov_r   <= 1'b0;
            z_r    <= {PW{1'b0}};
        end else begin
            busy_r <= busy_n;
            done_r <= done_n;
            ov_r   <= ov_n;
            z_r    <= z_n;
        end
    end

    // Accumulator of product bits; never overflows since (2^W-1)^N_IN < 2^PW.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {PW{1'b0}};
        end else if (accept_s) begin
            acc_r <= {PW{1'b0}};
        end else begin
            acc_r <= acc_next_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign ov   = ov_r;
    assign z    = z_r;

endmodule

// File: tb/tb_dsc_mul_nway.sv
// Directed self-checking bench: default 3x4 instance, an early-exit instance
// and a 2x3 instance swept over all operand pairs.
module tb_dsc_mul_nway;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_en = 1'b1, a_start = 1'b0, a_busy, a_done, a_ov;
    logic [11:0] a_ops = 12'd0, a_z;
    logic        b_en = 1'b1, b_start = 1'b0, b_busy, b_done, b_ov;
    logic [11:0] b_ops = 12'd0, b_z;
    logic        c_en = 1'b1, c_start = 1'b0, c_busy, c_done, c_ov;
    logic [5:0]  c_ops = 6'd0, c_z;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    logic busy_ok;

    dsc_mul_nway #(.N_IN(3), .W(4), .EARLY_EXIT(0)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .start(a_start), .ops(a_ops),
        .busy(a_busy), .done(a_done), .z(a_z), .ov(a_ov));

    dsc_mul_nway #(.N_IN(3), .W(4), .EARLY_EXIT(1)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .start(b_start), .ops(b_ops),
        .busy(b_busy), .done(b_done), .z(b_z), .ov(b_ov));

    dsc_mul_nway #(.N_IN(2), .W(3), .EARLY_EXIT(0)) dut_c (
        .clk(clk), .rst(rst), .en(c_en), .start(c_start), .ops(c_ops),
        .busy(c_busy), .done(c_done), .z(c_z), .ov(c_ov));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [11:0] o);
        @(negedge clk); a_ops = o; a_start = 1'b1;
        @(negedge clk); a_start = 1'b0;
    endtask

    task automatic start_b(input logic [11:0] o);
        @(negedge clk); b_ops = o; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
    endtask

    task automatic start_c(input logic [5:0] o);
        @(negedge clk); c_ops = o; c_start = 1'b1;
        @(negedge clk); c_start = 1'b0;
    endtask

    // Cycle count includes the edge that sampled start.
    task automatic wait_a(output int n);
        n = 1;
        while (a_done !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    endtask

    task automatic wait_b(output int n);
        n = 1;
        while (b_done !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    endtask

    task automatic wait_c(output int n);
        n = 1;
        while (c_done !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", a_busy, 1'b0);
        check("rst_done", a_done, 1'b0);
        check("rst_ov", a_ov, 1'b0);
        check("rst_z", a_z, 12'd0);
        rst = 1'b1;

        // All-max operands.
        start_a({4'd15, 4'd15, 4'd15});
        check("max_busy", a_busy, 1'b1);
        wait_a(cyc);
        check("max_lat", cyc, 4097);
        check("max_z", a_z, 3375);
        @(negedge clk);
        check("max_ov", a_ov, 1'b1);
        check("max_done_pulse", a_done, 1'b0);
        check("max_busy_after", a_busy, 1'b0);

        start_a({4'd7, 4'd5, 4'd3});
        wait_a(cyc);
        check("p357_lat", cyc, 4097);
        check("p357_z", a_z, 105);

        start_a({4'd4, 4'd9, 4'd0});
        wait_a(cyc);
        check("zero_lat", cyc, 4097);
        check("zero_z", a_z, 0);

        // Pause: en low for 100 cycles partway through the run.
        start_a({4'd13, 4'd6, 4'd10});
        cyc = 1;
        busy_ok = 1'b1;
        while (a_done !== 1'b1 && cyc < 6000) begin
            if (cyc == 2000) a_en = 1'b0;
            if (cyc == 2100) a_en = 1'b1;
            if (a_busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        check("pause_busy_held", busy_ok, 1'b1);
        check("pause_lat", cyc, 4197);
        check("pause_z", a_z, 780);

        // Back-to-back: start in DONE is ignored, next IDLE start accepted.
        start_a({4'd7, 4'd5, 4'd3});
        wait_a(cyc);
        check("b2b_first_z", a_z, 105);
        a_ops = {4'd1, 4'd1, 4'd1};
        a_start = 1'b1;
        @(negedge clk);
        check("b2b_done_start_ignored", a_busy, 1'b0);
        check("b2b_done_low", a_done, 1'b0);
        a_ops = {4'd1, 4'd3, 4'd2};
        @(negedge clk);
        a_start = 1'b0;
        check("b2b_accepted", a_busy, 1'b1);
        check("b2b_z_held", a_z, 105);
        wait_a(cyc);
        check("b2b_lat", cyc, 4097);
        check("b2b_z", a_z, 6);

        // Reset mid-run, then a second start during the new run.
        start_a({4'd15, 4'd15, 4'd15});
        repeat (50) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", a_busy, 1'b0);
        check("midrst_z", a_z, 12'd0);
        check("midrst_ov", a_ov, 1'b0);
        rst = 1'b1;
        start_a({4'd2, 4'd2, 4'd2});
        repeat (20) @(negedge clk);
        a_ops = {4'd15, 4'd15, 4'd15};
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a(cyc);
        check("restart_ignored_lat", cyc, 4076);
        check("restart_ignored_z", a_z, 8);

        // Early-exit instance.
        start_b({4'd7, 4'd5, 4'd3});
        wait_b(cyc);
        check("ee_normal_lat", cyc, 4097);
        check("ee_normal_z", b_z, 105);
        start_b({4'd4, 4'd9, 4'd0});
        wait_b(cyc);
        check("ee_zero_lat", cyc, 1);
        check("ee_zero_z", b_z, 0);
        @(negedge clk);
        check("ee_zero_ov", b_ov, 1'b1);

        // 2x3 instance: every operand pair.
        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                start_c({3'(y), 3'(x)});
                wait_c(cyc);
                check($sformatf("sweep_lat_%0d_%0d", x, y), cyc, 65);
                check($sformatf("sweep_z_%0d_%0d", x, y), c_z, x * y);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
